vec_mac: RTL and testbench
==========================

VEC_MAC -- requirements
Module: vec_mac

Interface
REQ-001 Parameter VEC_LEN, default 16: signed 8-bit element pairs per dot product; legal range 2..256.
REQ-002 Parameter ACC_W, default 24: accumulator and result width; must be >= 17+clog2(VEC_LEN).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 act_in  input  8  signed activation from the upstream 8-bit delay-register stage.
REQ-006 wgt_in  input  8  signed weight, aligned with act_in.
REQ-007 in_valid  input  1  act_in/wgt_in pair valid this cycle.
REQ-008 in_ready  output  1  block accepts a pair this cycle.
REQ-009 flush  input  1  synchronous abort of the partial dot product.
REQ-010 result  output  ACC_W  signed dot-product result.
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream consumes result.
REQ-013 count  output  clog2(VEC_LEN)+1  pairs accepted in the current vector.

Function
REQ-014 The block has two states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-015 A pair is accepted on a rising edge where in_valid=1 and in_ready=1; accepted pairs in ACCUM are never dropped.
REQ-016 On acceptance: acc <= acc + sign_ext(act_in*wgt_in); the product is full 16-bit signed and is sign-extended to ACC_W.
REQ-017 On acceptance with count=VEC_LEN-1: result <= acc + product (post Configuration processing), acc <= 0, count <= 0, state <= HOLD.
REQ-018 Latency: out_valid rises on the edge that accepts the last pair; result is visible the following cycle.
REQ-019 In HOLD, result and out_valid stay stable until out_ready=1; that edge returns state to ACCUM with out_valid=0.
REQ-020 No pair is accepted in the HOLD-exit cycle; the first pair of the next vector is accepted at the earliest one cycle later.
REQ-021 flush=1 in ACCUM: acc <= 0 and count <= 0; any pair presented the same cycle is discarded.
REQ-022 flush=1 in HOLD: ignored; the pending result is still delivered.
REQ-023 in_valid=0 cycles in ACCUM: acc and count hold (bubbles allowed).
REQ-024 Arithmetic does not overflow inside the range set by REQ-002; no wrap detection is implemented.

Reset
REQ-025 rst=1 on a rising edge: state <= ACCUM, acc <= 0, count <= 0, result <= 0, out_valid <= 0; in_ready = 1 from the first cycle after reset.
REQ-026 rst overrides flush, in_valid and out_ready; rst in HOLD discards the pending result.
REQ-027 No output is X after the first reset edge.

Configuration
REQ-028 Macro VEC_MAC_RELU_EN: when defined, a negative final sum is written to result as 0 and a non-negative sum is written unchanged.
REQ-029 When VEC_MAC_RELU_EN is undefined, result holds the raw signed sum; acc behaviour is identical in both builds.

Verification (VEC_LEN=4, ACC_W=24)
REQ-030 Reset, then pairs (1,1),(2,3),(-4,5),(127,127) back-to-back with out_ready=1 -> out_valid for one cycle, result=16116 (0x003EF4); in_ready low that cycle.
REQ-031 Pairs (-128,127)x4 with no RELU_EN -> result=-65024 (0xFF0200); with VEC_MAC_RELU_EN -> result=0.
REQ-032 Vector from REQ-030 with out_ready held 0 for 5 cycles, in_valid held 1 -> result stable and in_ready=0 for all 5 cycles; no pair accepted until 1 cycle after out_ready=1.
REQ-033 Accept 2 pairs (10,10),(10,10), assert flush with (99,99) valid, then accept (1,1)x4 -> result=4 and count reads 0 after flush.
REQ-034 Bubbles: pairs (3,3),(3,3),(3,3),(3,3) with in_valid low on alternate cycles -> result=36; count steps 1,2,3 then 0.
REQ-035 rst asserted in HOLD with out_ready=0 -> next cycle out_valid=0, result=0, in_ready=1, count=0.

Source files
------------

// File: rtl/vec_mac_if.sv
// vec_mac_if -- operand stream, control and result bus of vec_mac.
//
// slave  (vec_mac side): receives act_in, wgt_in, in_valid, flush and
//                        out_ready; drives in_ready, result, out_valid, count.
// master (source/sink) : the mirror image of slave.
//
// VEC_LEN and ACC_W must match the vec_mac instance on the slave side.
interface vec_mac_if #(
  parameter int VEC_LEN = 16,
  parameter int ACC_W   = 24
);
  localparam int CNT_W = $clog2(VEC_LEN) + 1;

  logic [7:0]       act_in;
  logic [7:0]       wgt_in;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic [ACC_W-1:0] result;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] count;

  modport slave (
    input  act_in, wgt_in, in_valid, flush, out_ready,
    output in_ready, result, out_valid, count
  );

  modport master (
    output act_in, wgt_in, in_valid, flush, out_ready,
    input  in_ready, result, out_valid, count
  );
endinterface

// File: rtl/vec_mac.sv
// vec_mac -- signed 8x8 multiply-accumulate over VEC_LEN element pairs.
//
// Ports:
//   clock  : rising-edge clock for all state
//   rst    : synchronous, active-high reset
//   bus    : vec_mac_if.slave
//              act_in/wgt_in/in_valid/in_ready : operand pair handshake
//              flush                           : abort the partial dot product
//              result/out_valid/out_ready      : result handshake
//              count                           : pairs accepted in current vector
//
// Build option: VEC_MAC_RELU_EN -- when defined, a negative final sum is
// written to result as zero. The accumulator is unaffected either way.
//
// state | meaning
// ------+------------------------------------------------------------
// ACCUM | accepting pairs (in_ready=1); flush clears the partial sum
// HOLD  | result valid (out_valid=1); waits for out_ready, ignores flush
module vec_mac #(
  parameter int VEC_LEN = 16,
  parameter int ACC_W   = 24
) (
  input  logic      clock,
  input  logic      rst,
  vec_mac_if.slave  bus
);
  localparam int CNT_W = $clog2(VEC_LEN) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic signed [7:0]  act_s;
  logic signed [7:0]  wgt_s;
  logic signed [15:0] prod;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   final_sum;

  // The true product of two signed bytes always fits in 16 bits, so a
  // 16x16 multiply truncated to 16 bits is exact.
  assign act_s    = $signed(bus.act_in);
  assign wgt_s    = $signed(bus.wgt_in);
  assign prod     = 16'(act_s) * 16'(wgt_s);
  assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
  assign sum      = acc_q + prod_ext;

`ifdef VEC_MAC_RELU_EN
  assign final_sum = sum[ACC_W-1] ? '0 : sum;
`else
  assign final_sum = sum;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      ACCUM: begin
        // flush wins over a pair presented in the same cycle
        if (bus.flush) begin
          acc_d = '0;
          cnt_d = '0;
        end else if (bus.in_valid) begin
          if (cnt_q == LAST) begin
            res_d   = final_sum;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Handshake flags come straight from the state, so the HOLD-exit cycle
  // still shows in_ready=0 and no pair can slip in there.
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.result    = res_q;
  assign bus.count     = cnt_q;
endmodule

// File: tb/tb_vec_mac.sv
module tb_vec_mac;
  localparam int VL = 4;
  localparam int AW = 24;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  vec_mac_if #(.VEC_LEN(VL), .ACC_W(AW)) bus ();

  vec_mac #(.VEC_LEN(VL), .ACC_W(AW)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pair(input logic [7:0] a, input logic [7:0] w);
    bus.act_in   = a;
    bus.wgt_in   = w;
    bus.in_valid = 1'b1;
    step();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, ".count"},     32'(bus.count),     32'd0);
  endtask

  initial begin
    bus.act_in    = '0;
    bus.wgt_in    = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;

    // reset state
    chk_idle("reset");
    chk("reset.result", 32'(bus.result), 32'd0);

    // basic vector, back-to-back, out_ready high
    bus.out_ready = 1'b1;
    pair(8'd1, 8'd1);
    chk("v1.count1", 32'(bus.count), 32'd1);
    pair(8'd2, 8'd3);
    chk("v1.count2", 32'(bus.count), 32'd2);
    pair(-8'sd4, 8'd5);
    chk("v1.count3", 32'(bus.count), 32'd3);
    pair(8'd127, 8'd127);
    bus.in_valid = 1'b0;
    chk("v1.out_valid", 32'(bus.out_valid), 32'd1);
    chk("v1.in_ready",  32'(bus.in_ready),  32'd0);
    chk("v1.result",    32'(bus.result),    32'h0000_3EF4);
    chk("v1.count0",    32'(bus.count),     32'd0);
    step();
    chk_idle("v1.exit");

    // most negative products
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pair(-8'sd128, 8'd127);
    bus.in_valid = 1'b0;
    chk("neg.out_valid", 32'(bus.out_valid), 32'd1);
`ifdef VEC_MAC_RELU_EN
    chk("neg.result", 32'(bus.result), 32'd0);
`else
    chk("neg.result", 32'(bus.result), 32'h00FF_0200);
`endif
    bus.out_ready = 1'b1;
    step();
    chk_idle("neg.exit");

    // backpressure: out_ready low for 5 cycles while in_valid stays high
    bus.out_ready = 1'b0;
    pair(8'd1, 8'd1);
    pair(8'd2, 8'd3);
    pair(-8'sd4, 8'd5);
    pair(8'd127, 8'd127);
    bus.act_in = 8'd5;
    bus.wgt_in = 8'd5;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp.result",    32'(bus.result),    32'h0000_3EF4);
      chk("bp.in_ready",  32'(bus.in_ready),  32'd0);
      chk("bp.out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    step();
    chk_idle("bp.exit");
    bus.out_ready = 1'b0;
    step();
    chk("bp.first_accept", 32'(bus.count), 32'd1);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    chk("bp.flush_count", 32'(bus.count), 32'd0);

    // flush mid-vector with a valid pair that must be discarded
    bus.out_ready = 1'b1;
    pair(8'd10, 8'd10);
    pair(8'd10, 8'd10);
    chk("fl.count2", 32'(bus.count), 32'd2);
    bus.flush = 1'b1;
    pair(8'd99, 8'd99);
    bus.flush = 1'b0;
    chk("fl.count0", 32'(bus.count), 32'd0);
    chk("fl.out_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) pair(8'd1, 8'd1);
    bus.in_valid = 1'b0;
    chk("fl.out_valid2", 32'(bus.out_valid), 32'd1);
    chk("fl.result", 32'(bus.result), 32'd4);
    step();

    // bubbles between pairs
    pair(8'd3, 8'd3);
    chk("bub.count1", 32'(bus.count), 32'd1);
    bus.in_valid = 1'b0;
    step();
    chk("bub.hold1", 32'(bus.count), 32'd1);
    pair(8'd3, 8'd3);
    chk("bub.count2", 32'(bus.count), 32'd2);
    bus.in_valid = 1'b0;
    step();
    pair(8'd3, 8'd3);
    chk("bub.count3", 32'(bus.count), 32'd3);
    bus.in_valid = 1'b0;
    step();
    chk("bub.out_valid_early", 32'(bus.out_valid), 32'd0);
    pair(8'd3, 8'd3);
    bus.in_valid = 1'b0;
    chk("bub.count0", 32'(bus.count), 32'd0);
    chk("bub.result", 32'(bus.result), 32'd36);
    chk("bub.out_valid", 32'(bus.out_valid), 32'd1);
    step();

    // flush in HOLD is ignored
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pair(8'd2, 8'd2);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush    = 1'b0;
    chk("hfl.out_valid", 32'(bus.out_valid), 32'd1);
    chk("hfl.result",    32'(bus.result),    32'd16);
    bus.out_ready = 1'b1;
    step();
    chk_idle("hfl.exit");

    // reset in HOLD discards the pending result
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) pair(8'd1, 8'd1);
    bus.in_valid = 1'b0;
    chk("hrst.pre_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("hrst");
    chk("hrst.result", 32'(bus.result), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
